pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
- Parametrised elastic register pipeline. Replaces fixed-width single-stage flops with one block that is configurable in width, depth and reset value.
- Each stage carries a valid bit, and the chain supports valid/ready back-pressure, bubble collapsing, a synchronous flush and an occupancy count.
- Sits between datapath blocks wherever a multi-cycle, stallable delay is needed.

Parameters:
- WIDTH, 32, data width in bits (>=1)
- DEPTH, 4, number of register stages (>=1)
- RST_VAL, 0, data register value after reset (WIDTH bits)
- FLUSH_CLR_DATA, 0, when 1 flush also loads RST_VAL into all data registers

Ports:
- clk  input  1  clock, all state updates on rising edge
- rstn  input  1  synchronous reset, active-low
- flush  input  1  synchronous clear of all stage valids
- in_valid  input  1  upstream beat present
- in_ready  output  1  pipeline accepts beat this cycle
- in_data  input  WIDTH  upstream data
- out_valid  output  1  valid bit of last stage
- out_ready  input  1  downstream accepts beat
- out_data  output  WIDTH  data of last stage
- occupancy  output  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- Reset is active-low, synchronous, clock clk.
- Reset (rstn=0 at a clk edge):
  - all stage valids v[k] go to 0
  - all data d[k] go to RST_VAL
  - occupancy goes to 0
  - out_valid=0, out_data=RST_VAL
  - in_ready=1 while rstn=0; beats offered during reset are dropped
- Stage indexing: stage 0 takes in_valid/in_data; stage DEPTH-1 drives out_valid/out_data.
- Ready chain (combinational):
  - rdy[DEPTH-1] = !v[DEPTH-1] | out_ready
  - rdy[k] = !v[k] | rdy[k+1]
  - in_ready = rdy[0]
  - in_ready may depend combinationally on out_ready.
- Stage update when rdy[k]=1:
  - v[k] <= upstream valid
  - d[k] <= upstream data, only if upstream valid=1; otherwise d[k] holds
- Stage hold when rdy[k]=0: v[k] and d[k] hold.
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Latency: on an empty pipe, a beat accepted in cycle N has out_valid=1 in cycle N+DEPTH.
- Throughput: one beat per cycle sustained while out_ready=1.
- Bubbles: an empty stage is refilled even while downstream stages are stalled, so gaps collapse under stall.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold until out_fire.
- Full: occupancy==DEPTH with out_ready=0 gives in_ready=0. Full with out_ready=1 gives in_ready=1: simultaneous in and out, occupancy unchanged.
- Occupancy register:
  - next = occupancy + in_fire - out_fire
  - always equals popcount(v)
  - never exceeds DEPTH and never goes below 0
- Flush (rstn=1, flush=1):
  - next cycle all v[k]=0 and occupancy=0
  - data holds, or loads RST_VAL if FLUSH_CLR_DATA=1
  - an out_fire in the flush cycle counts as delivered to downstream
  - an in_valid beat in the flush cycle is dropped and does not enter the pipe
  - flush has priority over every load
- Reset has priority over flush.
- Reset mid-operation: all in-flight beats are discarded with no partial output.
- DEPTH=1: single skid-free register; in_ready = !v[0] | out_ready.

Test Plan:
- Reset: hold rstn=0 for 2 cycles with in_valid=1 and RST_VAL=32'hDEAD_BEEF -> out_valid=0, out_data=32'hDEADBEEF, occupancy=0 after release.
- Latency/throughput: DEPTH=4, out_ready=1, send 0x1..0x8 back-to-back from cycle 0 -> out_valid first high at cycle 4, outputs 0x1..0x8 in consecutive cycles, occupancy steady at 4.
- Back-pressure: out_ready=0, push 5 beats -> 4 accepted, in_ready=0 after the 4th, occupancy=4, out_data=0x1 stable. Then raise out_ready -> data drains in order and the 5th beat is accepted the same cycle as the first out_fire.
- Bubble collapse: send 0xA, idle 2 cycles, send 0xB, with out_ready=0 -> both beats end in stages 3 and 2, occupancy=2, and no bubble sits between them.
- Flush: 3 beats in flight, flush=1 with out_ready=1 and in_valid=1 (0xC) -> the stage-3 beat is delivered that cycle, next cycle occupancy=0 and out_valid=0, 0xC is never output.
- Reset mid-stream: full pipe, pulse rstn=0 for 1 cycle -> all valids cleared and no stale beat appears afterward; a new beat emerges after exactly DEPTH cycles.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: parameterised elastic register pipeline.
//   DEPTH stages, each with a valid bit and WIDTH-bit data register, joined by
//   a combinational ready chain. An empty stage accepts new data even while a
//   stage further downstream is stalled, so gaps between beats close up.
//   flush clears all valids in one cycle. occupancy counts the valid stages.
//
// Ports:
//   clk        clock, rising edge
//   rstn       synchronous reset, active-low
//   flush      synchronous clear of every stage valid
//   in_valid   upstream beat present
//   in_ready   pipe accepts a beat this cycle; forced to 1 during reset
//   in_data    upstream data
//   out_valid  valid bit of the last stage
//   out_ready  downstream accepts a beat
//   out_data   data of the last stage
//   occupancy  number of valid stages
module pipe_reg_chain #(
  parameter int               WIDTH          = 32,
  parameter int               DEPTH          = 4,
  parameter logic [WIDTH-1:0] RST_VAL        = '0,
  parameter bit               FLUSH_CLR_DATA = 1'b0,
  localparam int              OCC_W          = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0]            v_q;
  logic [DEPTH-1:0][WIDTH-1:0] d_q;
  logic [DEPTH-1:0]            rdy;
  logic [DEPTH-1:0]            up_v;
  logic [DEPTH-1:0][WIDTH-1:0] up_d;
  logic [OCC_W-1:0]            occ_q, occ_d;
  logic                        in_fire, out_fire;

  // Ready flows backwards: a stage can load if it is empty or its successor
  // can load. The last stage looks at out_ready.
  assign rdy[DEPTH-1] = !v_q[DEPTH-1] | out_ready;

  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign up_v[k] = in_valid;
        assign up_d[k] = in_data;
      end else begin : g_body
        assign up_v[k] = v_q[k-1];
        assign up_d[k] = d_q[k-1];
      end

      if (k < DEPTH-1) begin : g_rdy
        assign rdy[k] = !v_q[k] | rdy[k+1];
      end

      always_ff @(posedge clk) begin
        if (!rstn) begin
          v_q[k] <= 1'b0;
          d_q[k] <= RST_VAL;
        end else if (flush) begin
          v_q[k] <= 1'b0;
          if (FLUSH_CLR_DATA) d_q[k] <= RST_VAL;
        end else if (rdy[k]) begin
          v_q[k] <= up_v[k];
          // Bubbles move without disturbing the data register.
          if (up_v[k]) d_q[k] <= up_d[k];
        end
      end
    end
  endgenerate

  // During reset the pipe advertises ready; anything offered is dropped.
  assign in_ready  = !rstn | rdy[0];
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);
    if (flush) occ_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain (WIDTH=32, DEPTH=4, RST_VAL=DEADBEEF).
// Inputs change 1ns after each rising edge; outputs are checked at that point,
// so registered outputs show post-edge state and in_ready shows the current
// combinational value.
module tb_pipe_reg_chain;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RV = 32'hDEAD_BEEF;

  logic             clk = 1'b0;
  logic             rstn, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data;
  logic [2:0]       occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_reg_chain #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RV), .FLUSH_CLR_DATA(1'b0)
  ) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---- reset with a beat offered ----
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    step();
    chk("rst_in_ready2", {31'b0, in_ready}, 32'd1);
    rstn = 1'b1; in_valid = 1'b0;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, RV);
    chk("rst_occ", {29'b0, occupancy}, 32'd0);
    step();
    chk("rst_dropped", {31'b0, out_valid}, 32'd0);

    // ---- latency / throughput: 1..8 back to back, out_ready=1 ----
    out_ready = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      in_valid = (c < 8);
      in_data  = 32'(c + 1);
      #0;
      chk("lat_in_ready", {31'b0, in_ready}, 32'd1);
      chk("lat_out_valid", {31'b0, out_valid}, (c >= 4 && c < 12) ? 32'd1 : 32'd0);
      if (c >= 4 && c < 12) chk("lat_out_data", out_data, 32'(c - 3));
      chk("lat_occ", {29'b0, occupancy}, (c < 4) ? 32'(c) : (c <= 8) ? 32'd4 : 32'(12 - c));
      step();
    end
    in_valid = 1'b0;

    // ---- back-pressure: 5 beats with out_ready=0 ----
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i + 1);
      #0;
      chk("bp_in_ready", {31'b0, in_ready}, (i < 4) ? 32'd1 : 32'd0);
      chk("bp_occ", {29'b0, occupancy}, 32'(i));
      step();
    end
    chk("bp_full_occ", {29'b0, occupancy}, 32'd4);
    chk("bp_full_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_hold_data", out_data, 32'h1);
      step();
    end
    out_ready = 1'b1;
    #0;
    chk("bp_ready_thru", {31'b0, in_ready}, 32'd1);
    chk("bp_first_out", out_data, 32'h1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_drain_data", out_data, 32'(i + 2));
      chk("bp_drain_occ", {29'b0, occupancy}, 32'(4 - i));
      step();
    end
    chk("bp_empty_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_empty_occ", {29'b0, occupancy}, 32'd0);

    // ---- bubble collapse: A, 2 idle, B, out_ready=0 ----
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; step();
    in_valid = 1'b0; step(); step();
    in_valid = 1'b1; in_data = 32'hB; step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("bub_occ", {29'b0, occupancy}, 32'd2);
    chk("bub_head", out_data, 32'hA);
    out_ready = 1'b1;
    step();
    chk("bub_next_valid", {31'b0, out_valid}, 32'd1);
    chk("bub_next_data", out_data, 32'hB);
    step();
    chk("bub_done_valid", {31'b0, out_valid}, 32'd0);
    chk("bub_done_occ", {29'b0, occupancy}, 32'd0);

    // ---- flush with 3 beats in flight ----
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11; step();
    in_data = 32'h22; step();
    in_data = 32'h33; step();
    in_valid = 1'b0; step();
    chk("fl_pre_occ", {29'b0, occupancy}, 32'd3);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hC;
    #0;
    chk("fl_deliver_valid", {31'b0, out_valid}, 32'd1);
    chk("fl_deliver_data", out_data, 32'h11);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_occ", {29'b0, occupancy}, 32'd0);
    chk("fl_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_data_hold", out_data, 32'h11);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("fl_no_c", {31'b0, out_valid}, 32'd0);
    end

    // ---- reset mid-stream on a full pipe ----
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'(32'h41 + i); step();
    end
    in_valid = 1'b0;
    chk("mr_full_occ", {29'b0, occupancy}, 32'd4);
    rstn = 1'b0; step();
    rstn = 1'b1;
    chk("mr_occ", {29'b0, occupancy}, 32'd0);
    chk("mr_valid", {31'b0, out_valid}, 32'd0);
    chk("mr_data", out_data, RV);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h99; step();
    in_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      chk("mr_lat_valid", {31'b0, out_valid}, (c == 4) ? 32'd1 : 32'd0);
      if (c == 4) chk("mr_lat_data", out_data, 32'h99);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
